// File: rtl/ukf_pkg.sv
// Shared fixed-point definitions for the UKF pipeline stages.
// Holds the data/accumulator widths, the stage FSM state type and the ACC_W->DATA_W clamp.
package ukf_pkg;

    localparam int DATA_W  = 32;
    localparam int FRAC_W  = 16;
    localparam int GUARD_W = 4;
    localparam int ACC_W   = DATA_W + GUARD_W;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_ACCUM  = 4'd1,
        ST_OUTPUT = 4'd2,
        ST_DONE   = 4'd3
    } state_t;

    // Value fits in DATA_W exactly when the guard bits and the DATA_W sign bit all agree.
    function automatic logic signed [DATA_W-1:0] sat_acc(input logic signed [ACC_W-1:0] a);
        logic [GUARD_W:0] top;
        top = a[ACC_W-1:DATA_W-1];
        if (top == '0 || top == '1) begin
            sat_acc = a[DATA_W-1:0];
        end else if (a[ACC_W-1]) begin
            sat_acc = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat_acc = {1'b0, {(DATA_W-1){1'b1}}};
        end
    endfunction

endpackage

// File: rtl/ukf_sigma_mean_if.sv
// Sigma-element input stream and mean-element output stream of the weighted-mean stage.
// Both streams use valid/ready: a beat moves on a clock edge where valid && ready; a
// producer holding valid keeps its payload stable until that edge.
interface ukf_sigma_mean_if #(
    parameter int N_STATE = 6
);
    import ukf_pkg::*;

    localparam int IDX_W = (N_STATE > 1) ? $clog2(N_STATE) : 1;

    logic              sig_valid;
    logic              sig_ready;
    logic [DATA_W-1:0] sig_data;
    logic              mean_valid;
    logic              mean_ready;
    logic [DATA_W-1:0] mean_data;
    logic [IDX_W-1:0]  mean_idx;

    modport master (
        output sig_valid, sig_data, mean_ready,
        input  sig_ready, mean_valid, mean_data, mean_idx
    );

    modport slave (
        input  sig_valid, sig_data, mean_ready,
        output sig_ready, mean_valid, mean_data, mean_idx
    );

endinterface

// File: rtl/ukf_fx_mac.sv
// Fixed-point weighted term: full signed product, arithmetic shift by FRAC_W,
// and the low ACC_W bits of the result (wraps like the accumulator it feeds).
module ukf_fx_mac
    import ukf_pkg::*;
(
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] w,
    output logic signed [ACC_W-1:0]  p
);

    logic signed [2*DATA_W-1:0] prod;
    logic                       unused_bits;

    assign prod = a * w;
    // Selecting bits FRAC_W upward equals an arithmetic right shift then truncation to ACC_W.
    assign p = prod[FRAC_W +: ACC_W];
    assign unused_bits = ^{prod[FRAC_W-1:0], prod[2*DATA_W-1:FRAC_W+ACC_W]};

endmodule

// File: rtl/ukf_sigma_mean.sv
// Weighted mean of the propagated sigma points: one weighted accumulator per state
// element, then the saturated mean vector streamed to the covariance stage.
module ukf_sigma_mean
    import ukf_pkg::*;
#(
    parameter int N_STATE = 6,
    parameter int N_SIGMA = 2 * N_STATE + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] w0,
    input  logic [DATA_W-1:0] wi,
    ukf_sigma_mean_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic [3:0]        state_dbg
);

    localparam int IDX_W = (N_STATE > 1) ? $clog2(N_STATE) : 1;
    localparam int SIG_W = $clog2(N_SIGMA);
    localparam logic [IDX_W-1:0] ELEM_LAST = IDX_W'(N_STATE - 1);
    localparam logic [SIG_W-1:0] SIG_LAST  = SIG_W'(N_SIGMA - 1);

    state_t state;
    state_t state_nxt;

    logic signed [DATA_W-1:0] w0_q;
    logic signed [DATA_W-1:0] wi_q;
    logic signed [DATA_W-1:0] w_cur;
    logic signed [ACC_W-1:0]  acc [N_STATE];
    logic signed [ACC_W-1:0]  term;
    logic [IDX_W-1:0]         elem_cnt;
    logic [IDX_W-1:0]         out_cnt;
    logic [SIG_W-1:0]         sig_cnt;

    logic beat;
    logic last_beat;
    logic out_beat;
    logic last_out;
    logic take_start;

    assign beat       = bus.sig_valid && bus.sig_ready;
    assign last_beat  = beat && (sig_cnt == SIG_LAST) && (elem_cnt == ELEM_LAST);
    assign out_beat   = bus.mean_valid && bus.mean_ready;
    assign last_out   = out_beat && (out_cnt == ELEM_LAST);
    assign take_start = (state == ST_IDLE) && start;

    assign w_cur = (sig_cnt == '0) ? w0_q : wi_q;

    ukf_fx_mac u_mac (
        .a (bus.sig_data),
        .w (w_cur),
        .p (term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start)     state_nxt = ST_ACCUM;
            ST_ACCUM:  if (last_beat) state_nxt = ST_OUTPUT;
            ST_OUTPUT: if (last_out)  state_nxt = ST_DONE;
            ST_DONE:                  state_nxt = ST_IDLE;
            default:                  state_nxt = ST_IDLE;
        endcase
    end

    // Accumulators stay readable after DONE; only reset or the next start clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            w0_q     <= '0;
            wi_q     <= '0;
            elem_cnt <= '0;
            sig_cnt  <= '0;
            out_cnt  <= '0;
            for (int i = 0; i < N_STATE; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (take_start) begin
                w0_q     <= w0;
                wi_q     <= wi;
                elem_cnt <= '0;
                sig_cnt  <= '0;
                out_cnt  <= '0;
                for (int i = 0; i < N_STATE; i++) begin
                    acc[i] <= '0;
                end
            end
            if (beat) begin
                acc[elem_cnt] <= acc[elem_cnt] + term;
                if (elem_cnt == ELEM_LAST) begin
                    elem_cnt <= '0;
                    sig_cnt  <= sig_cnt + 1'b1;
                end else begin
                    elem_cnt <= elem_cnt + 1'b1;
                end
            end
            if (out_beat) begin
                out_cnt <= last_out ? '0 : out_cnt + 1'b1;
            end
        end
    end

    assign bus.sig_ready  = (state == ST_ACCUM);
    assign bus.mean_valid = (state == ST_OUTPUT);
    assign bus.mean_idx   = out_cnt;
    assign bus.mean_data  = sat_acc(acc[out_cnt]);
    assign busy           = (state != ST_IDLE);
    assign done           = (state == ST_DONE);
    assign state_dbg      = state;

endmodule

// File: tb/tb_ukf_sigma_mean.sv
// Bench for ukf_sigma_mean: directed and random sigma sets against a plain-arithmetic
// weighted-mean model, with stall, restart-ignore, abort and latency checks.
module tb_ukf_sigma_mean;
    import ukf_pkg::*;

    localparam int N_STATE = 6;
    localparam int N_SIGMA = 2 * N_STATE + 1;
    localparam int N_BEATS = N_SIGMA * N_STATE;
    localparam int LAT_EXP = 1 + N_BEATS + N_STATE + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] w0;
    logic [DATA_W-1:0] wi;
    logic              busy;
    logic              done;
    logic [3:0]        state_dbg;

    ukf_sigma_mean_if #(.N_STATE(N_STATE)) bus ();

    ukf_sigma_mean #(.N_STATE(N_STATE), .N_SIGMA(N_SIGMA)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .w0        (w0),
        .wi        (wi),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int tests = 0;
    int fails = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [2:0]        exp_idx_q[$];
    logic [DATA_W-1:0] data_arr [N_BEATS];
    int done_cnt    = 0;
    int done_cyc    = 0;
    int stall_cycles = 0;
    bit stall_en    = 1'b0;
    bit ready_rand  = 1'b0;
    int stall_left  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Weighted mean straight from the definition: sum of truncated fixed-point products,
    // wrapped to the accumulator width, then clamped to the data range.
    function automatic logic [DATA_W-1:0] model_mean(input int e, input logic [31:0] w0v,
                                                      input logic [31:0] wiv);
        longint sum;
        longint x;
        longint w;
        longint v;
        logic [ACC_W-1:0] a36;
        sum = 0;
        for (int s = 0; s < N_SIGMA; s++) begin
            x = $signed(data_arr[s * N_STATE + e]);
            w = (s == 0) ? $signed(w0v) : $signed(wiv);
            sum += (x * w) >>> FRAC_W;
        end
        a36 = sum[ACC_W-1:0];
        v = $signed(a36);
        if (v > 64'sd2147483647)       model_mean = 32'h7FFF_FFFF;
        else if (v < -64'sd2147483648) model_mean = 32'h8000_0000;
        else                           model_mean = v[31:0];
    endfunction

    task automatic load_model(input logic [31:0] w0v, input logic [31:0] wiv);
        for (int e = 0; e < N_STATE; e++) begin
            exp_q.push_back(model_mean(e, w0v, wiv));
            exp_idx_q.push_back(3'(e));
        end
    endtask

    // ---------------- output sink ----------------
    always @(posedge clk) begin
        #1;
        if (stall_en && bus.mean_valid && bus.mean_idx == 3'd2 && stall_left > 0) begin
            bus.mean_ready = 1'b0;
            stall_left--;
        end else if (ready_rand) begin
            bus.mean_ready = ($urandom_range(0, 2) != 0);
        end else begin
            bus.mean_ready = 1'b1;
        end
    end

    // ---------------- compare process ----------------
    logic [DATA_W-1:0] prev_data;
    logic [2:0]        prev_idx;
    bit                prev_stall = 1'b0;

    always @(negedge clk) begin
        if (bus.mean_valid) begin
            if (prev_stall) begin
                check("stall_data", bus.mean_data, prev_data);
                check("stall_idx", bus.mean_idx, prev_idx);
            end
            if (bus.mean_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_out: got idx %0d data %0h, want no beat", bus.mean_idx, bus.mean_data);
                end else begin
                    check("mean_data", bus.mean_data, exp_q.pop_front());
                    check("mean_idx", bus.mean_idx, exp_idx_q.pop_front());
                end
            end else begin
                stall_cycles++;
            end
        end
        prev_stall = bus.mean_valid && !bus.mean_ready;
        prev_data  = bus.mean_data;
        prev_idx   = bus.mean_idx;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_start(input logic [31:0] a, input logic [31:0] b, output int scyc);
        @(posedge clk); #1;
        start = 1'b1;
        w0    = a;
        wi    = b;
        scyc  = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed(input int lo, input int hi, input bit gaps);
        bit ok;
        int guard;
        int g;
        for (int i = lo; i < hi; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                repeat (g) begin
                    bus.sig_valid = 1'b0;
                    bus.sig_data  = $urandom;
                    @(posedge clk); #1;
                end
            end
            bus.sig_valid = 1'b1;
            bus.sig_data  = data_arr[i];
            ok    = 1'b0;
            guard = 0;
            while (!ok && guard < 200) begin
                @(negedge clk);
                ok = bus.sig_ready;
                @(posedge clk); #1;
                guard++;
            end
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL sig_ready_timeout: beat %0d not taken in 200 cycles", i);
                bus.sig_valid = 1'b0;
                return;
            end
        end
        bus.sig_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int prev);
        int k;
        k = 0;
        while (done_cnt == prev && k < 600) begin
            @(posedge clk);
            k++;
        end
        if (done_cnt == prev) begin
            tests++;
            fails++;
            $display("FAIL %s_done_timeout: no done in 600 cycles", name);
        end
        repeat (4) @(posedge clk);
        check({name, "_done_count"}, done_cnt - prev, 1);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic run(input string name, input logic [31:0] w0v, input logic [31:0] wiv,
                       input bit gaps, output int scyc);
        int prev;
        prev = done_cnt;
        load_model(w0v, wiv);
        do_start(w0v, wiv, scyc);
        feed(0, N_BEATS, gaps);
        wait_done(name, prev);
    endtask

    task automatic fill_const(input logic [31:0] v);
        for (int i = 0; i < N_BEATS; i++) data_arr[i] = v;
    endtask

    // ---------------- main sequence ----------------
    int scyc;
    int prev;

    initial begin
        rst = 1'b1;
        start = 1'b0;
        w0 = '0;
        wi = '0;
        bus.sig_valid = 1'b0;
        bus.sig_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", state_dbg, 4'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sig_ready", bus.sig_ready, 1'b0);
        check("rst_mean_valid", bus.mean_valid, 1'b0);
        check("rst_mean_data", bus.mean_data, 32'h0);
        check("rst_mean_idx", bus.mean_idx, 3'd0);

        // Test 1: only sigma 0 counts; stall-free so latency is checked too.
        fill_const(32'h7FFF_0000);
        for (int e = 0; e < N_STATE; e++) data_arr[e] = (e + 1) << FRAC_W;
        for (int e = 0; e < N_STATE; e++)
            check($sformatf("pin_t1_%0d", e), model_mean(e, 32'h0001_0000, 32'h0), (e + 1) << FRAC_W);
        run("t1", 32'h0001_0000, 32'h0, 1'b0, scyc);
        check("latency", done_cyc - scyc + 1, LAT_EXP);

        // Test 2: 12 sigmas of 0.25 * 4.0.
        fill_const(32'h0004_0000);
        check("pin_t2", model_mean(3, 32'h0, 32'h0000_4000), 32'h000C_0000);
        run("t2", 32'h0, 32'h0000_4000, 1'b0, scyc);

        // Test 3: positive saturation, then -13.0.
        fill_const(32'h7FFF_0000);
        check("pin_t3a", model_mean(0, 32'h0001_0000, 32'h0001_0000), 32'h7FFF_FFFF);
        run("t3a", 32'h0001_0000, 32'h0001_0000, 1'b0, scyc);
        fill_const(32'hFFFF_0000);
        check("pin_t3b", model_mean(5, 32'h0001_0000, 32'h0001_0000), 32'hFFF3_0000);
        run("t3b", 32'h0001_0000, 32'h0001_0000, 1'b0, scyc);

        // Test 4: input gaps plus a 3-cycle output stall at idx 2.
        fill_const(32'h0004_0000);
        stall_cycles = 0;
        stall_left   = 3;
        stall_en     = 1'b1;
        run("t4", 32'h0, 32'h0000_4000, 1'b1, scyc);
        stall_en = 1'b0;
        check("t4_stall_cycles", stall_cycles, 3);

        // Test 5a: a start during ACCUM with different weights must not disturb the run.
        prev = done_cnt;
        load_model(32'h0, 32'h0000_4000);
        do_start(32'h0, 32'h0000_4000, scyc);
        feed(0, 20, 1'b0);
        @(posedge clk); #1;
        start = 1'b1;
        w0 = 32'h0003_0000;
        wi = 32'h0007_0000;
        @(posedge clk); #1;
        start = 1'b0;
        feed(20, N_BEATS, 1'b1);
        wait_done("t5a", prev);

        // Test 5b: reset after 40 beats aborts without a done, then a clean random run.
        prev = done_cnt;
        for (int i = 0; i < N_BEATS; i++) data_arr[i] = $urandom;
        do_start(32'h0001_0000, 32'h0000_8000, scyc);
        feed(0, 40, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_state", state_dbg, 4'd0);
        check("abort_busy", busy, 1'b0);
        check("abort_sig_ready", bus.sig_ready, 1'b0);
        check("abort_mean_valid", bus.mean_valid, 1'b0);
        repeat (100) @(posedge clk);
        check("abort_no_done", done_cnt - prev, 0);
        for (int i = 0; i < N_BEATS; i++) data_arr[i] = $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000;
        run("t5b", 32'h0000_3000, 32'h0000_1800, 1'b1, scyc);

        // Random runs: moderate values, then full-range values that wrap and saturate.
        ready_rand = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N_BEATS; i++) data_arr[i] = $urandom_range(0, 32'h01FF_FFFF) - 32'h0100_0000;
            run($sformatf("rnd%0d", r), $urandom_range(0, 32'h0002_0000) - 32'h0001_0000,
                $urandom_range(0, 32'h0001_0000), 1'b1, scyc);
        end
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N_BEATS; i++) data_arr[i] = $urandom;
            run($sformatf("wide%0d", r), $urandom, $urandom, 1'b1, scyc);
        end
        ready_rand = 1'b0;

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
